complemento_para_sinal: RTL and testbench

//  Bit-serial converter from a WIDTH-bit two's-complement result to sign + magnitude.
//  It is the output-side counterpart of the calculator's input conversion, which

---
 rtl/complemento_para_sinal.sv | 111 +++++++++++
 tb/tb_complemento_para_sinal.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/complemento_para_sinal.sv
// Bit-serial converter from a WIDTH-bit two's-complement value to sign + magnitude.
// Resolves one magnitude bit per clock using the copy-until-first-one-then-invert rule.
module complemento_para_sinal #(
    parameter int WIDTH = 9
) (
    input  logic             relogio,
    input  logic             reiniciar,
    input  logic             iniciar,
    input  logic [WIDTH-1:0] numero,
    output logic             ocupado,
    output logic             pronto,
    output logic             sinal,
    output logic [WIDTH-2:0] magnitude,
    output logic             erro
);
    localparam int MAG_W = WIDTH - 1;
    localparam int IDX_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAG_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [MAG_W-1:0] cap;
    logic [MAG_W-1:0] res;
    logic [MAG_W-1:0] res_next;
    logic [IDX_W-1:0] idx;
    logic             neg;
    logic             visto_um;
    logic             bit_in;
    logic             bit_out;
    logic             last_bit;
    logic             min_neg;

    // NOTE: reset is sampled synchronously here, so it lives inside the clocked block
    // and has no entry in the sensitivity list.
    always_ff @(posedge relogio) begin
        if (reiniciar) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (iniciar) state_next = CONV;
            CONV:    if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Once a 1 has been seen below this bit, a negative input has every remaining bit inverted.
    always_comb begin
        bit_in        = cap[idx];
        bit_out       = bit_in ^ (neg & visto_um);
        last_bit      = (state == CONV) && (idx == LAST_IDX);
        min_neg       = neg && (cap == '0);
        res_next      = res;
        res_next[idx] = bit_out;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge relogio) begin
        if (reiniciar) begin
            cap       <= '0;
            res       <= '0;
            idx       <= '0;
            neg       <= 1'b0;
            visto_um  <= 1'b0;
            sinal     <= 1'b0;
            magnitude <= '0;
            erro      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iniciar) begin
                        cap      <= numero[MAG_W-1:0];
                        neg      <= numero[WIDTH-1];
                        res      <= '0;
                        idx      <= '0;
                        visto_um <= 1'b0;
                    end
                end
                CONV: begin
                    res      <= res_next;
                    visto_um <= visto_um | bit_in;
                    idx      <= idx + IDX_W'(1);
                    if (last_bit) begin
                        sinal     <= neg;
                        magnitude <= min_neg ? '1 : res_next;
                        erro      <= min_neg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ocupado = (state == CONV);
    assign pronto  = (state == DONE);

endmodule

// File: tb/tb_complemento_para_sinal.sv
// Self-checking bench: arithmetic reference model checked every cycle, plus directed
// vectors with hand-computed results.
module tb_complemento_para_sinal;
    localparam int W = 9;

    logic           clk = 1'b0;
    logic           reiniciar;
    logic           iniciar;
    logic [W-1:0]   numero;
    logic           ocupado;
    logic           pronto;
    logic           sinal;
    logic [W-2:0]   magnitude;
    logic           erro;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // reference model state
    bit             checking = 1'b0;
    bit             act      = 1'b0;
    int             cap_cyc  = 0;
    int             due_cyc  = 0;
    logic           p_s, m_s;
    logic [W-2:0]   p_m, m_m;
    logic           p_e, m_e;

    complemento_para_sinal #(.WIDTH(W)) dut (
        .relogio   (clk),
        .reiniciar (reiniciar),
        .iniciar   (iniciar),
        .numero    (numero),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .sinal     (sinal),
        .magnitude (magnitude),
        .erro      (erro)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Sign and absolute value from plain signed arithmetic.
    function automatic void model(input logic [W-1:0] n, output logic s,
                                  output logic [W-2:0] m, output logic e);
        int v;
        v = int'($signed(n));
        if (v == -(1 << (W - 1))) begin
            s = 1'b1; m = '1; e = 1'b1;
        end else if (v < 0) begin
            s = 1'b1; m = (W-1)'(-v); e = 1'b0;
        end else begin
            s = 1'b0; m = (W-1)'(v); e = 1'b0;
        end
    endfunction

    // Called at the negedge right after the capture edge.
    task automatic model_start(input logic [W-1:0] n);
        model(n, p_s, p_m, p_e);
        cap_cyc = cyc;
        due_cyc = cyc + W - 1;
        act     = 1'b1;
    endtask

    task automatic model_reset();
        act = 1'b0;
        m_s = 1'b0;
        m_m = '0;
        m_e = 1'b0;
    endtask

    // Compare process: every cycle, between edges.
    initial begin
        bit exp_pronto, exp_busy;
        forever begin
            @(negedge clk);
            #1;
            if (checking) begin
                exp_pronto = act && (cyc == due_cyc);
                exp_busy   = act && (cyc >= cap_cyc) && (cyc < due_cyc);
                if (exp_pronto) begin
                    m_s = p_s; m_m = p_m; m_e = p_e;
                end
                check("cyc_pronto", 32'(pronto), 32'(exp_pronto));
                check("cyc_ocupado", 32'(ocupado), 32'(exp_busy));
                check("cyc_sinal", 32'(sinal), 32'(m_s));
                check("cyc_magnitude", 32'(magnitude), 32'(m_m));
                check("cyc_erro", 32'(erro), 32'(m_e));
            end
        end
    end

    // Wait out a conversion whose capture edge just passed and pin its result.
    task automatic finish_conv(input string name, input logic s, input logic [W-2:0] m, input logic e);
        repeat (W - 1) @(negedge clk);
        #2;
        check({name, "_pronto"}, 32'(pronto), 32'd1);
        check({name, "_sinal"}, 32'(sinal), 32'(s));
        check({name, "_magnitude"}, 32'(magnitude), 32'(m));
        check({name, "_erro"}, 32'(erro), 32'(e));
    endtask

    task automatic convert(input string name, input logic [W-1:0] n,
                           input logic s, input logic [W-2:0] m, input logic e);
        @(negedge clk);
        numero  = n;
        iniciar = 1'b1;
        @(negedge clk);
        model_start(n);
        iniciar = 1'b0;
        numero  = W'($urandom);
        finish_conv(name, s, m, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reiniciar = 1'b1;
        iniciar   = 1'b0;
        numero    = '0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_ocupado", 32'(ocupado), 32'd0);
        check("reset_pronto", 32'(pronto), 32'd0);
        check("reset_sinal", 32'(sinal), 32'd0);
        check("reset_magnitude", 32'(magnitude), 32'd0);
        check("reset_erro", 32'(erro), 32'd0);
        @(negedge clk);
        reiniciar = 1'b0;
        model_reset();
        checking = 1'b1;

        convert("pos5", 9'h005, 1'b0, 8'd5, 1'b0);
        convert("neg5", 9'h1FB, 1'b1, 8'd5, 1'b0);
        convert("neg1", 9'h1FF, 1'b1, 8'd1, 1'b0);
        convert("minneg", 9'h100, 1'b1, 8'hFF, 1'b1);
        convert("pos255", 9'h0FF, 1'b0, 8'hFF, 1'b0);
        convert("zero", 9'h000, 1'b0, 8'd0, 1'b0);
        convert("neg127", 9'h181, 1'b1, 8'd127, 1'b0);
        convert("pos170", 9'h0AA, 1'b0, 8'd170, 1'b0);

        // iniciar held high and numero toggled during the conversion
        @(negedge clk);
        numero  = 9'h1F6;
        iniciar = 1'b1;
        @(negedge clk);
        model_start(9'h1F6);
        for (int i = 0; i < W - 2; i++) begin
            numero = W'($urandom);
            @(negedge clk);
        end
        numero = W'($urandom);
        @(negedge clk);
        #2;
        check("hold_pronto", 32'(pronto), 32'd1);
        check("hold_sinal", 32'(sinal), 32'd1);
        check("hold_magnitude", 32'(magnitude), 32'd10);
        check("hold_erro", 32'(erro), 32'd0);
        numero = 9'h07F;
        @(negedge clk);
        #2;
        check("hold_done_ignored", 32'(ocupado), 32'd0);
        @(negedge clk);
        model_start(9'h07F);
        iniciar = 1'b0;
        #2;
        check("hold_restart_busy", 32'(ocupado), 32'd1);
        finish_conv("hold_next", 1'b0, 8'd127, 1'b0);

        // reset on the 4th CONV edge aborts the conversion
        @(negedge clk);
        numero  = 9'h1F0;
        iniciar = 1'b1;
        @(negedge clk);
        model_start(9'h1F0);
        iniciar = 1'b0;
        repeat (3) @(negedge clk);
        reiniciar = 1'b1;
        @(negedge clk);
        reiniciar = 1'b0;
        model_reset();
        #2;
        check("abort_ocupado", 32'(ocupado), 32'd0);
        check("abort_sinal", 32'(sinal), 32'd0);
        check("abort_magnitude", 32'(magnitude), 32'd0);
        check("abort_erro", 32'(erro), 32'd0);
        repeat (10) @(negedge clk);
        convert("neg32", 9'h1E0, 1'b1, 8'd32, 1'b0);

        repeat (3) @(negedge clk);
        #2;
        check("hold_after_idle", 32'(magnitude), 32'd32);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
